// File: rtl/pipe_pkg.sv
// Shared definitions for the back-end pipeline registers of the 5-stage MIPS core.
// Holds the default datapath widths, the bundles carried through the EX/MEM and
// MEM/WB registers, all-zero bubble constants and the write-back source encodings.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Write-back source select, as stored in the memToReg field.
  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_MEM = 1'b1;

  // Fields held in the EX/MEM register (the valid bit lives in the stage register).
  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
  } ex_mem_t;

  // Fields held in the MEM/WB register; wb_data is already the selected result.
  typedef struct packed {
    logic              reg_write;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] wb_data;
  } mem_wb_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with a valid bit.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (clears valid and data)
//   hold        keep valid and data as they are
//   clr_valid   force valid to 0 at the edge; data holds (wins over hold)
//   in_valid    valid bit to capture on a normal edge
//   d / q       W-bit payload in / out
//   valid       stage holds a real instruction
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         clr_valid,
  input  logic         in_valid,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  // NOTE: the payload is cleared on reset as well as the valid bit; it is a plain
  // register (not a RAM array), and zeroed fields keep the ungated outputs at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (clr_valid)  valid <= 1'b0;
      else if (!hold) valid <= in_valid;
      // A killed or held slot keeps its old fields; only valid matters downstream.
      if (!(hold || clr_valid)) q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   mem_stall            data memory busy: hold EX/MEM, bubble into MEM/WB
//   flush                kill the instruction being captured into EX/MEM
//   ex_*                 instruction leaving the EX stage
//   mem_rdata            data memory read data (same cycle as mem_re)
//   EX_MEM_regWrite/rd   to forwarding unit; EX_MEM_aluResult forwarded value
//   mem_addr/wdata/we/re data memory interface driven from EX/MEM
//   MEM_WB_regWrite/rd   register-file write port and forwarding unit
//   wb_data              register-file write data / forwarded MEM/WB value
//   retire_count         instructions retired through MEM/WB (wraps)
// DATA_W/REG_W must match the pipe_pkg bundle widths.
module ex_mem_wb_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_W  = pipe_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_regWrite,
  input  logic              ex_memToReg,
  input  logic              ex_memRead,
  input  logic              ex_memWrite,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [DATA_W-1:0] ex_aluResult,
  input  logic [DATA_W-1:0] ex_storeData,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              EX_MEM_regWrite,
  output logic [REG_W-1:0]  EX_MEM_rd,
  output logic [DATA_W-1:0] EX_MEM_aluResult,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              MEM_WB_regWrite,
  output logic [REG_W-1:0]  MEM_WB_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       retire_count
);

  ex_mem_t     em_d, em_q;
  mem_wb_t     mw_d, mw_q;
  logic        em_valid, mw_valid;
  logic [31:0] retire_cnt;

  // NOTE: every field gets a default before being overwritten, so this block
  // cannot infer a latch even if a field is later left out.
  always_comb begin
    em_d            = EX_MEM_BUBBLE;
    // r0 is hard-wired zero: an rd of 0 never becomes a write or a forward.
    em_d.reg_write  = ex_regWrite & (ex_rd != '0);
    em_d.mem_to_reg = ex_memToReg;
    em_d.mem_read   = ex_memRead;
    em_d.mem_write  = ex_memWrite;
    em_d.rd         = ex_rd;
    em_d.alu_result = ex_aluResult;
    em_d.store_data = ex_storeData;
  end

  // Stall holds the whole slot (strobes stay up, repeated store is harmless);
  // flush drops only the valid bit and wins over the hold.
  pipe_stage_reg #(.W($bits(ex_mem_t))) u_ex_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (mem_stall),
    .clr_valid (flush),
    .in_valid  (ex_valid),
    .d         (em_d),
    .valid     (em_valid),
    .q         (em_q)
  );

  always_comb begin
    mw_d           = MEM_WB_BUBBLE;
    mw_d.reg_write = em_q.reg_write;
    mw_d.rd        = em_q.rd;
    mw_d.wb_data   = (em_q.mem_to_reg == WB_SRC_MEM) ? mem_rdata : em_q.alu_result;
  end

  // While memory stalls, the instruction in EX/MEM has not finished, so MEM/WB
  // receives a bubble; a flush of EX does not affect what moves into MEM/WB.
  pipe_stage_reg #(.W($bits(mem_wb_t))) u_mem_wb (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (1'b0),
    .clr_valid (mem_stall),
    .in_valid  (em_valid),
    .d         (mw_d),
    .valid     (mw_valid),
    .q         (mw_q)
  );

  // An instruction retires on the edge that moves it out of MEM/WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        retire_cnt <= '0;
    else if (mw_valid) retire_cnt <= retire_cnt + 32'd1;
  end

  // Control outputs are qualified by valid; data and rd pass through ungated.
  assign EX_MEM_regWrite  = em_valid & em_q.reg_write;
  assign EX_MEM_rd        = em_q.rd;
  assign EX_MEM_aluResult = em_q.alu_result;
  assign mem_addr         = em_q.alu_result;
  assign mem_wdata        = em_q.store_data;
  assign mem_we           = em_valid & em_q.mem_write;
  assign mem_re           = em_valid & em_q.mem_read;
  assign MEM_WB_regWrite  = mw_valid & mw_q.reg_write;
  assign MEM_WB_rd        = mw_q.rd;
  assign wb_data          = mw_q.wb_data;
  assign retire_count     = retire_cnt;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Self-checking bench for ex_mem_wb_pipe: directed scenarios followed by random
// traffic, all outputs compared every cycle against an instruction-level model.
module tb_ex_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_stall, flush;
  logic        ex_valid, ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite;
  logic [4:0]  ex_rd;
  logic [31:0] ex_aluResult, ex_storeData, mem_rdata;
  logic        EX_MEM_regWrite, mem_we, mem_re, MEM_WB_regWrite;
  logic [4:0]  EX_MEM_rd, MEM_WB_rd;
  logic [31:0] EX_MEM_aluResult, mem_addr, mem_wdata, wb_data, retire_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem_wb_pipe dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_stall        (mem_stall),
    .flush            (flush),
    .ex_valid         (ex_valid),
    .ex_regWrite      (ex_regWrite),
    .ex_memToReg      (ex_memToReg),
    .ex_memRead       (ex_memRead),
    .ex_memWrite      (ex_memWrite),
    .ex_rd            (ex_rd),
    .ex_aluResult     (ex_aluResult),
    .ex_storeData     (ex_storeData),
    .mem_rdata        (mem_rdata),
    .EX_MEM_regWrite  (EX_MEM_regWrite),
    .EX_MEM_rd        (EX_MEM_rd),
    .EX_MEM_aluResult (EX_MEM_aluResult),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_we           (mem_we),
    .mem_re           (mem_re),
    .MEM_WB_regWrite  (MEM_WB_regWrite),
    .MEM_WB_rd        (MEM_WB_rd),
    .wb_data          (wb_data),
    .retire_count     (retire_count)
  );

  // Reference model: one instruction record in the memory stage and one in
  // write-back, plus a count of instructions that have left write-back.
  typedef struct {
    bit          live;
    bit          writes_reg;
    bit          from_mem;
    bit          is_load;
    bit          is_store;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] sdata;
  } mem_instr_t;

  typedef struct {
    bit          live;
    bit          writes_reg;
    logic [4:0]  rd;
    logic [31:0] result;
  } wb_instr_t;

  mem_instr_t  in_mem;
  wb_instr_t   in_wb;
  logic [31:0] retired;

  task automatic model_reset();
    in_mem  = '{default: '0};
    in_wb   = '{default: '0};
    retired = '0;
  endtask

  // Applies one clock edge using the inputs currently on the pins.
  task automatic model_edge();
    if (in_wb.live) retired = retired + 32'd1;
    if (mem_stall) begin
      in_wb.live = 1'b0;
    end else begin
      in_wb.live       = in_mem.live;
      in_wb.writes_reg = in_mem.writes_reg;
      in_wb.rd         = in_mem.rd;
      in_wb.result     = in_mem.from_mem ? mem_rdata : in_mem.addr;
    end
    if (flush) begin
      in_mem.live = 1'b0;
    end else if (!mem_stall) begin
      in_mem.live       = ex_valid;
      in_mem.writes_reg = ex_regWrite && (ex_rd != 5'd0);
      in_mem.from_mem   = ex_memToReg;
      in_mem.is_load    = ex_memRead;
      in_mem.is_store   = ex_memWrite;
      in_mem.rd         = ex_rd;
      in_mem.addr       = ex_aluResult;
      in_mem.sdata      = ex_storeData;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ":EX_MEM_regWrite"},  32'(EX_MEM_regWrite),  32'(in_mem.live && in_mem.writes_reg));
    check({tag, ":EX_MEM_rd"},        32'(EX_MEM_rd),        32'(in_mem.rd));
    check({tag, ":EX_MEM_aluResult"}, EX_MEM_aluResult,      in_mem.addr);
    check({tag, ":mem_addr"},         mem_addr,              in_mem.addr);
    check({tag, ":mem_wdata"},        mem_wdata,             in_mem.sdata);
    check({tag, ":mem_we"},           32'(mem_we),           32'(in_mem.live && in_mem.is_store));
    check({tag, ":mem_re"},           32'(mem_re),           32'(in_mem.live && in_mem.is_load));
    check({tag, ":MEM_WB_regWrite"},  32'(MEM_WB_regWrite),  32'(in_wb.live && in_wb.writes_reg));
    check({tag, ":MEM_WB_rd"},        32'(MEM_WB_rd),        32'(in_wb.rd));
    check({tag, ":wb_data"},          wb_data,               in_wb.result);
    check({tag, ":retire_count"},     retire_count,          retired);
  endtask

  task automatic drive(input bit v, input bit rw, input bit m2r, input bit mr, input bit mw,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd);
    ex_valid     = v;
    ex_regWrite  = rw;
    ex_memToReg  = m2r;
    ex_memRead   = mr;
    ex_memWrite  = mw;
    ex_rd        = rd;
    ex_aluResult = alu;
    ex_storeData = sd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(tag);
  endtask

  // Pulse reset low between edges and check that everything clears at once.
  task automatic async_reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    check({tag, ":mem_we_now"}, 32'(mem_we), 32'd0);
    check({tag, ":retire_now"}, retire_count, 32'd0);
    #1 rst_n = 1'b1;
  endtask

  logic [31:0] cnt0;

  initial begin
    rst_n     = 1'b0;
    mem_stall = 1'b0;
    flush     = 1'b0;
    mem_rdata = 32'd0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_all("reset_init");

    // Reset pulse with a live write instruction captured.
    drive(1, 1, 0, 0, 0, 5'd5, 32'h55, 32'd0);
    tick("rst_setup");
    check("rst_setup_emrw", 32'(EX_MEM_regWrite), 32'd1);
    idle();
    async_reset_pulse("rst_pulse");
    check("rst_emrw", 32'(EX_MEM_regWrite), 32'd0);

    // ALU op: latency 1 to EX/MEM, 2 to MEM/WB, 3 to retire.
    drive(1, 1, 0, 0, 0, 5'd3, 32'h1234, 32'd0);
    tick("alu_e1");
    check("alu_emrw", 32'(EX_MEM_regWrite), 32'd1);
    check("alu_emrd", 32'(EX_MEM_rd), 32'd3);
    idle();
    tick("alu_e2");
    check("alu_mwrw", 32'(MEM_WB_regWrite), 32'd1);
    check("alu_mwrd", 32'(MEM_WB_rd), 32'd3);
    check("alu_wbd",  wb_data, 32'h1234);
    tick("alu_e3");
    check("alu_retire", retire_count, 32'd1);

    // Load: memory data selected for write-back.
    drive(1, 1, 1, 1, 0, 5'd7, 32'h40, 32'd0);
    tick("ld_e1");
    check("ld_re",   32'(mem_re), 32'd1);
    check("ld_addr", mem_addr, 32'h40);
    idle();
    mem_rdata = 32'hDEAD;
    tick("ld_e2");
    check("ld_wbd", wb_data, 32'hDEAD);
    check("ld_mwrd", 32'(MEM_WB_rd), 32'd7);
    mem_rdata = 32'd0;

    // Store held by a 3-cycle memory stall, then retires exactly once.
    drive(1, 0, 0, 0, 1, 5'd9, 32'h80, 32'hCAFE);
    tick("st_e1");
    check("st_we", 32'(mem_we), 32'd1);
    cnt0 = retired;
    idle();
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("st_stall");
      check("stall_we",     32'(mem_we), 32'd1);
      check("stall_wdata",  mem_wdata, 32'hCAFE);
      check("stall_mwrw",   32'(MEM_WB_regWrite), 32'd0);
      check("stall_retire", retire_count, cnt0);
    end
    mem_stall = 1'b0;
    tick("st_rel1");
    check("st_rel_we", 32'(mem_we), 32'd0);
    tick("st_rel2");
    check("st_retire_once", retire_count, cnt0 + 32'd1);
    tick("st_rel3");
    check("st_retire_after", retire_count, cnt0 + 32'd1);

    // rd=0 never writes; a flushed store never strobes.
    drive(1, 1, 0, 0, 0, 5'd0, 32'h55, 32'd0);
    tick("rd0");
    check("rd0_emrw", 32'(EX_MEM_regWrite), 32'd0);
    drive(1, 0, 0, 0, 1, 5'd2, 32'h90, 32'hBEEF);
    flush = 1'b1;
    tick("flush_e1");
    check("flush_we", 32'(mem_we), 32'd0);
    flush = 1'b0;
    idle();
    tick("flush_e2");
    check("flush_we2", 32'(mem_we), 32'd0);

    // Reset while a store is stalled: strobe drops without a clock edge.
    drive(1, 0, 0, 0, 1, 5'd4, 32'hA0, 32'h1111);
    tick("rst_st_e1");
    idle();
    mem_stall = 1'b1;
    tick("rst_st_stall");
    check("rst_st_we_before", 32'(mem_we), 32'd1);
    async_reset_pulse("rst_mid_store");
    mem_stall = 1'b0;

    // Random traffic with stalls and flushes.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 31)), $urandom, $urandom);
      mem_rdata = $urandom;
      mem_stall = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      tick("rand");
    end
    mem_stall = 1'b0;
    flush     = 1'b0;
    idle();
    tick("drain1");
    tick("drain2");

    // Retire counter wrap.
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt;
    retired = 32'hFFFF_FFFF;
    check("wrap_preset", retire_count, 32'hFFFF_FFFF);
    drive(1, 1, 0, 0, 0, 5'd6, 32'h66, 32'd0);
    tick("wrap_e1");
    idle();
    tick("wrap_e2");
    check("wrap_hold", retire_count, 32'hFFFF_FFFF);
    tick("wrap_e3");
    check("wrap_zero", retire_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
